// File: rtl/gpu_vram_pkg.sv
// Shared types and constants for the VRAM write path: fill FSM states,
// default address width / FIFO depth, and the buffered write entry.
package gpu_vram_pkg;

    localparam int VRAM_ADDR_WIDTH = 16;
    localparam int WR_FIFO_DEPTH   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fill_state_t;

    typedef struct packed {
        logic [VRAM_ADDR_WIDTH-1:0] addr;
        logic [7:0]                 data;
    } wr_entry_t;

endpackage

// File: rtl/vram_write_fifo.sv
// Synchronous FIFO holding CPU VRAM writes until the arbiter can issue them.
// The head entry is presented combinationally so it can be popped and issued
// in the same cycle.
module vram_write_fifo
    import gpu_vram_pkg::*;
#(
    parameter int   DEPTH = WR_FIFO_DEPTH,
    localparam int  PTR_W = $clog2(DEPTH),
    localparam int  LVL_W = PTR_W + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push_valid,
    output logic              o_push_ready,
    input  wr_entry_t         i_push_data,
    input  logic              i_pop,
    output wr_entry_t         o_head,
    output logic              o_empty,
    output logic              o_full,
    output logic [LVL_W-1:0]  o_level
);

    wr_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic               w_push;
    logic               w_pop;

    assign o_full       = (r_level == LVL_W'(DEPTH));
    assign o_empty      = (r_level == '0);
    assign o_push_ready = !o_full;
    assign o_level      = r_level;
    assign o_head       = r_mem[r_rd_ptr];
    assign w_push       = i_push_valid && !o_full;
    assign w_pop        = i_pop && !o_empty;

    // Storage array: written on accepted push, contents need no reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/vram_write_scheduler.sv
// Funnels CPU writes (via a FIFO) and the hardware fill engine onto one
// registered VRAM write port that is only driven while VRAM is writable.
// CPU writes always win over the fill; a fill simply pauses and resumes.
module vram_write_scheduler
    import gpu_vram_pkg::*;
#(
    parameter int ADDR_WIDTH = VRAM_ADDR_WIDTH,
    parameter int DEPTH      = WR_FIFO_DEPTH
) (
    input  logic                    gpu_clk,
    input  logic                    rst,
    input  logic                    writable,
    input  logic                    cpu_wr_valid,
    input  logic [ADDR_WIDTH-1:0]   cpu_wr_addr,
    input  logic [7:0]              cpu_wr_data,
    output logic                    cpu_wr_ready,
    input  logic                    fill_start,
    input  logic [ADDR_WIDTH-1:0]   fill_base,
    input  logic [ADDR_WIDTH-1:0]   fill_len,
    input  logic [7:0]              fill_value,
    output logic                    fill_busy,
    output logic                    fill_done,
    output logic                    overflow,
    input  logic                    clr_overflow,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    vram_we,
    output logic [ADDR_WIDTH-1:0]   vram_addr,
    output logic [7:0]              vram_data
);

    fill_state_t            r_state;
    fill_state_t            w_state_next;
    logic [ADDR_WIDTH-1:0]  r_base;
    logic [ADDR_WIDTH-1:0]  r_len;
    logic [ADDR_WIDTH-1:0]  r_count;
    logic [ADDR_WIDTH-1:0]  w_count_next;
    logic [7:0]             r_value;
    logic                   w_load;
    logic                   w_done_next;

    wr_entry_t              w_push_data;
    wr_entry_t              w_head;
    logic                   w_fifo_ready;
    logic                   w_fifo_empty;
    logic                   w_fifo_full;
    logic                   w_cpu_grant;
    logic                   w_fill_grant;
    logic [ADDR_WIDTH-1:0]  w_fill_addr;

    assign w_push_data.addr = cpu_wr_addr;
    assign w_push_data.data = cpu_wr_data;

    vram_write_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk        (gpu_clk),
        .i_rst        (rst),
        .i_push_valid (cpu_wr_valid),
        .o_push_ready (w_fifo_ready),
        .i_push_data  (w_push_data),
        .i_pop        (w_cpu_grant),
        .o_head       (w_head),
        .o_empty      (w_fifo_empty),
        .o_full       (w_fifo_full),
        .o_level      (fifo_level)
    );

    // Ready is gated by rst so nothing upstream sees a stale "ready" mid-reset.
    assign cpu_wr_ready = w_fifo_ready && !rst;
    assign fill_busy    = (r_state == RUN);

    // Grant: CPU FIFO first, then an active fill, only while writable.
    assign w_cpu_grant  = writable && !w_fifo_empty;
    assign w_fill_grant = writable && w_fifo_empty && (r_state == RUN);
    assign w_fill_addr  = r_base + r_count;   // wraps modulo 2^ADDR_WIDTH

    // Fill FSM state, parameters and completion pulse.
    always_ff @(posedge gpu_clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_base    <= '0;
            r_len     <= '0;
            r_value   <= '0;
            r_count   <= '0;
            fill_done <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            fill_done <= w_done_next;
            if (w_load) begin
                r_base  <= fill_base;
                r_len   <= fill_len;
                r_value <= fill_value;
            end
        end
    end

    // Fill FSM next state: a zero-length fill completes without entering RUN.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_load       = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (fill_start) begin
                    w_load = 1'b1;
                    if (fill_len == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_state_next = RUN;
                        w_count_next = '0;
                    end
                end
            end
            RUN: begin
                if (w_fill_grant) begin
                    w_count_next = r_count + ADDR_WIDTH'(1);
                    if (r_count == r_len - ADDR_WIDTH'(1)) begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Sticky overflow: a dropped CPU write beats a simultaneous clear.
    always_ff @(posedge gpu_clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (cpu_wr_valid && !w_fifo_ready) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    // Registered VRAM port; address/data hold when no write is issued.
    always_ff @(posedge gpu_clk or posedge rst) begin
        if (rst) begin
            vram_we   <= 1'b0;
            vram_addr <= '0;
            vram_data <= '0;
        end else if (w_cpu_grant) begin
            vram_we   <= 1'b1;
            vram_addr <= w_head.addr;
            vram_data <= w_head.data;
        end else if (w_fill_grant) begin
            vram_we   <= 1'b1;
            vram_addr <= w_fill_addr;
            vram_data <= r_value;
        end else begin
            vram_we   <= 1'b0;
        end
    end

    logic w_unused;
    assign w_unused = w_fifo_full;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Scoreboard bench for vram_write_scheduler: every expected VRAM write is
// queued when its stimulus is driven and compared when vram_we appears.
module tb_vram_write_scheduler;

    logic        gpu_clk = 1'b0;
    logic        rst = 1'b1;
    logic        writable = 1'b0;
    logic        cpu_wr_valid = 1'b0;
    logic [15:0] cpu_wr_addr = '0;
    logic [7:0]  cpu_wr_data = '0;
    logic        cpu_wr_ready;
    logic        fill_start = 1'b0;
    logic [15:0] fill_base = '0;
    logic [15:0] fill_len = '0;
    logic [7:0]  fill_value = '0;
    logic        fill_busy;
    logic        fill_done;
    logic        overflow;
    logic        clr_overflow = 1'b0;
    logic [3:0]  fifo_level;
    logic        vram_we;
    logic [15:0] vram_addr;
    logic [7:0]  vram_data;

    int          n_checks = 0;
    int          n_pass = 0;
    int          wr_count = 0;
    int          done_count = 0;
    int          wr0;
    int          done0;
    logic [23:0] sb [$];
    logic [23:0] mon_exp;

    vram_write_scheduler #(.ADDR_WIDTH(16), .DEPTH(8)) dut (
        .gpu_clk      (gpu_clk),
        .rst          (rst),
        .writable     (writable),
        .cpu_wr_valid (cpu_wr_valid),
        .cpu_wr_addr  (cpu_wr_addr),
        .cpu_wr_data  (cpu_wr_data),
        .cpu_wr_ready (cpu_wr_ready),
        .fill_start   (fill_start),
        .fill_base    (fill_base),
        .fill_len     (fill_len),
        .fill_value   (fill_value),
        .fill_busy    (fill_busy),
        .fill_done    (fill_done),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .fifo_level   (fifo_level),
        .vram_we      (vram_we),
        .vram_addr    (vram_addr),
        .vram_data    (vram_data)
    );

    always #5 gpu_clk = ~gpu_clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge gpu_clk);
            #1;
        end
    endtask

    task automatic sb_push(input logic [15:0] a, input logic [7:0] d);
        sb.push_back({a, d});
    endtask

    task automatic start_fill(input logic [15:0] b, input logic [15:0] l, input logic [7:0] v);
        fill_base  = b;
        fill_len   = l;
        fill_value = v;
        fill_start = 1'b1;
        tick(1);
        fill_start = 1'b0;
    endtask

    // Monitor: counts done pulses, compares each VRAM write with the scoreboard.
    always @(negedge gpu_clk) begin
        if (fill_done === 1'b1) done_count++;
        if (vram_we === 1'b1) begin
            wr_count++;
            $display("write #%0d addr=0x%04h data=0x%02h", wr_count, vram_addr, vram_data);
            if (sb.size() == 0) begin
                check_value("unexpected_write", 32'(vram_we), 32'd0);
            end else begin
                mon_exp = sb.pop_front();
                check_value("wr_addr", 32'(vram_addr), 32'(mon_exp[23:8]));
                check_value("wr_data", 32'(vram_data), 32'(mon_exp[7:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(1);
        check_value("rst_we", 32'(vram_we), 0);
        check_value("rst_ready", 32'(cpu_wr_ready), 0);
        check_value("rst_busy", 32'(fill_busy), 0);
        check_value("rst_done", 32'(fill_done), 0);
        check_value("rst_ovf", 32'(overflow), 0);
        check_value("rst_level", 32'(fifo_level), 0);
        rst = 1'b0;
        tick(1);
        check_value("ready_after_rst", 32'(cpu_wr_ready), 1);

        // Three back-to-back CPU writes, minimum latency
        writable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cpu_wr_valid = 1'b1;
            cpu_wr_addr  = 16'h2000 + 16'(i);
            cpu_wr_data  = 8'h11 * 8'(i + 1);
            sb_push(cpu_wr_addr, cpu_wr_data);
            tick(1);
            check_value("lat_we", 32'(vram_we), (i == 0) ? 32'd0 : 32'd1);
        end
        cpu_wr_valid = 1'b0;
        tick(1);
        check_value("lat_we3", 32'(vram_we), 1);
        tick(1);
        check_value("lat_we_off", 32'(vram_we), 0);

        // Fill FIFO while not writable, overflow on 9th and 10th
        writable = 1'b0;
        wr0 = wr_count;
        for (int i = 0; i < 10; i++) begin
            check_value("ready_fill", 32'(cpu_wr_ready), (i < 8) ? 32'd1 : 32'd0);
            cpu_wr_valid = 1'b1;
            cpu_wr_addr  = 16'h3000 + 16'(i);
            cpu_wr_data  = 8'h40 + 8'(i);
            if (i < 8) sb_push(cpu_wr_addr, cpu_wr_data);
            tick(1);
        end
        cpu_wr_valid = 1'b0;
        check_value("ovf_set", 32'(overflow), 1);
        check_value("level_full", 32'(fifo_level), 8);
        check_value("no_wr_blocked", 32'(wr_count - wr0), 0);
        writable = 1'b1;
        tick(12);
        check_value("drain_count", 32'(wr_count - wr0), 8);
        check_value("level_empty", 32'(fifo_level), 0);
        check_value("ovf_sticky", 32'(overflow), 1);
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        check_value("ovf_clr", 32'(overflow), 0);

        // Wrapping fill
        wr0 = wr_count;
        done0 = done_count;
        for (int k = 0; k < 4; k++) sb_push(16'hFFFE + 16'(k), 8'h00);
        start_fill(16'hFFFE, 16'd4, 8'h00);
        check_value("fill_busy_on", 32'(fill_busy), 1);
        for (int i = 0; i < 30; i++) begin
            if (!fill_busy && sb.size() == 0) break;
            tick(1);
        end
        check_value("fill_wrap_drain", 32'(sb.size()), 0);
        check_value("fill_busy_off", 32'(fill_busy), 0);
        tick(2);
        check_value("fill_wrap_count", 32'(wr_count - wr0), 4);
        check_value("fill_wrap_done", 32'(done_count - done0), 1);

        // Fill preempted by two CPU writes after its 5th write
        wr0 = wr_count;
        done0 = done_count;
        for (int k = 0; k < 5; k++) sb_push(16'h1000 + 16'(k), 8'hA5);
        sb_push(16'h5000, 8'hC1);
        sb_push(16'h5001, 8'hC2);
        for (int k = 5; k < 16; k++) sb_push(16'h1000 + 16'(k), 8'hA5);
        start_fill(16'h1000, 16'd16, 8'hA5);
        tick(4);
        check_value("pre_inject_count", 32'(wr_count - wr0), 4);
        cpu_wr_valid = 1'b1;
        cpu_wr_addr  = 16'h5000;
        cpu_wr_data  = 8'hC1;
        tick(1);
        cpu_wr_addr  = 16'h5001;
        cpu_wr_data  = 8'hC2;
        tick(1);
        cpu_wr_valid = 1'b0;
        tick(20);
        check_value("preempt_count", 32'(wr_count - wr0), 18);
        check_value("preempt_done", 32'(done_count - done0), 1);
        check_value("preempt_sb", 32'(sb.size()), 0);

        // Zero-length fill, then fill_start ignored during RUN
        wr0 = wr_count;
        done0 = done_count;
        start_fill(16'h0040, 16'd0, 8'h99);
        check_value("len0_done", 32'(fill_done), 1);
        check_value("len0_busy", 32'(fill_busy), 0);
        tick(1);
        check_value("len0_done_off", 32'(fill_done), 0);
        tick(3);
        check_value("len0_no_wr", 32'(wr_count - wr0), 0);
        check_value("len0_done_once", 32'(done_count - done0), 1);
        wr0 = wr_count;
        done0 = done_count;
        for (int k = 0; k < 3; k++) sb_push(16'h0100 + 16'(k), 8'h77);
        start_fill(16'h0100, 16'd3, 8'h77);
        start_fill(16'h0900, 16'd5, 8'hEE);
        tick(8);
        check_value("ignore_count", 32'(wr_count - wr0), 3);
        check_value("ignore_done", 32'(done_count - done0), 1);

        // Long fill paused by writable, then async reset mid-fill
        wr0 = wr_count;
        done0 = done_count;
        for (int k = 0; k < 40; k++) sb_push(16'h2000 + 16'(k), 8'h5A);
        start_fill(16'h2000, 16'd100, 8'h5A);
        for (int i = 0; i < 200; i++) begin
            if (wr_count - wr0 >= 40) break;
            tick(1);
        end
        writable = 1'b0;
        tick(4);
        check_value("pause_count", 32'(wr_count - wr0), 40);
        check_value("pause_busy", 32'(fill_busy), 1);
        for (int i = 0; i < 2; i++) begin
            cpu_wr_valid = 1'b1;
            cpu_wr_addr  = 16'h6000 + 16'(i);
            cpu_wr_data  = 8'hF0;
            tick(1);
        end
        cpu_wr_valid = 1'b0;
        check_value("pause_level", 32'(fifo_level), 2);
        #2;
        rst = 1'b1;
        #1;
        check_value("arst_we", 32'(vram_we), 0);
        check_value("arst_addr", 32'(vram_addr), 0);
        check_value("arst_data", 32'(vram_data), 0);
        check_value("arst_busy", 32'(fill_busy), 0);
        check_value("arst_done", 32'(fill_done), 0);
        check_value("arst_level", 32'(fifo_level), 0);
        check_value("arst_ready", 32'(cpu_wr_ready), 0);
        tick(2);
        rst = 1'b0;
        writable = 1'b1;
        tick(10);
        check_value("post_rst_no_wr", 32'(wr_count - wr0), 40);
        check_value("post_rst_no_done", 32'(done_count - done0), 0);
        check_value("post_rst_busy", 32'(fill_busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
